param_update_engine: RTL and testbench

- Downstream of the backward-pass stage. Holds all trainable parameters: w3 (4x5), w2 (5x9), b3 (4), b2 (5), 74 words total.
- On a start pulse it walks every parameter and fetches that parameter's delta from the backward stage over an indexed port. It then writes back the saturated sum param + delta.
- Also gives the forward pass a registered read port, and lets the host preload initial weights.

---
 rtl/dqn_pkg.sv | 28 ++
 rtl/sat_add16.sv | 21 ++
 rtl/param_update_engine.sv | 104 ++++++++++
 tb/tb_param_update_engine.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dqn_pkg.sv
// Shared constants for the DQN training datapath: Q6.10 format,
// parameter address map and update-engine FSM encodings.
package dqn_pkg;

  localparam int DATA_W     = 16;
  localparam int FRAC_W     = 10;
  localparam int ADDR_W     = 7;
  localparam int NUM_PARAMS = 74;

  localparam logic signed [DATA_W-1:0] ONE      = 16'sd1024;
  localparam logic signed [DATA_W-1:0] MAX      = 16'sh7FFF;
  localparam logic signed [DATA_W-1:0] MIN      = 16'sh8000;
  localparam logic signed [DATA_W-1:0] CLIP_VAL = 16'sd1024;

  localparam int W3_BASE = 0;
  localparam int W2_BASE = 20;
  localparam int B3_BASE = 65;
  localparam int B2_BASE = 69;

  localparam logic [ADDR_W-1:0] NUM_A = 7'(NUM_PARAMS);
  localparam logic [ADDR_W-1:0] LAST_A = 7'(NUM_PARAMS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_APPLY = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/sat_add16.sv
// Combinational 16-bit signed saturating adder; shared with the
// forward pass. ovf flags that the result was clamped.
module sat_add16
  import dqn_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum,
  output logic        ovf
);

  logic [16:0] s;

  always_comb begin
    s   = {a[15], a} + {b[15], b};
    ovf = s[16] != s[15];
    sum = s[15:0];
    if (ovf) sum = s[16] ? MIN : MAX;
  end

endmodule

// File: rtl/param_update_engine.sv
// Parameter store and update engine: mem[i] <= sat(mem[i] + delta[i]).
// Build option GRAD_CLIP_EN clamps each delta to +/-CLIP_VAL first.
module param_update_engine
  import dqn_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [6:0]  delta_addr,
  input  logic [15:0] delta_data,
  input  logic        init_we,
  input  logic [6:0]  init_addr,
  input  logic [15:0] init_data,
  input  logic [6:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic        sat_flag,
  output logic [15:0] pass_count
);

  logic [15:0] mem [NUM_PARAMS];
  logic [1:0]  state;
  logic [6:0]  idx;
  logic [15:0] w_r;
  logic [15:0] d_r;
  logic [15:0] delta_in;
  logic [15:0] sum;
  logic        ovf;

`ifdef GRAD_CLIP_EN
  always_comb begin
    delta_in = delta_data;
    if ($signed(delta_data) > CLIP_VAL)
      delta_in = CLIP_VAL;
    else if ($signed(delta_data) < -CLIP_VAL)
      delta_in = -CLIP_VAL;
  end
`else
  assign delta_in = delta_data;
`endif

  sat_add16 u_add (
    .a   (w_r),
    .b   (d_r),
    .sum (sum),
    .ovf (ovf)
  );

  assign busy = state != S_IDLE;
  assign done = state == S_DONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      w_r        <= '0;
      d_r        <= '0;
      delta_addr <= '0;
      rd_data    <= '0;
      sat_flag   <= 1'b0;
      pass_count <= '0;
      for (int i = 0; i < NUM_PARAMS; i++)
        mem[i] <= '0;
    end else begin
      // Non-blocking read: a same-edge write returns the old word.
      rd_data <= (rd_addr < NUM_A) ? mem[rd_addr] : '0;
      unique case (state)
        S_IDLE: begin
          if (init_we && init_addr < NUM_A)
            mem[init_addr] <= init_data;
          if (start) begin
            state      <= S_FETCH;
            idx        <= '0;
            delta_addr <= '0;
            sat_flag   <= 1'b0;
          end
        end
        S_FETCH: begin
          w_r   <= mem[idx];
          d_r   <= delta_in;
          state <= S_APPLY;
        end
        S_APPLY: begin
          mem[idx] <= sum;
          if (ovf) sat_flag <= 1'b1;
          if (idx == LAST_A) begin
            state <= S_DONE;
          end else begin
            idx        <= idx + 7'd1;
            delta_addr <= idx + 7'd1;
            state      <= S_FETCH;
          end
        end
        S_DONE: begin
          pass_count <= pass_count + 16'd1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_update_engine.sv
// Directed self-checking bench for param_update_engine.
// Expected values are hand-computed Q6.10 sums.
module tb_param_update_engine;

  logic        clk = 0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [6:0]  delta_addr;
  logic [15:0] delta_data;
  logic        init_we;
  logic [6:0]  init_addr;
  logic [15:0] init_data;
  logic [6:0]  rd_addr;
  logic [15:0] rd_data;
  logic        sat_flag;
  logic [15:0] pass_count;

  logic [15:0] dtab [128];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign delta_data = dtab[delta_addr];

  param_update_engine dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .delta_addr (delta_addr),
    .delta_data (delta_data),
    .init_we    (init_we),
    .init_addr  (init_addr),
    .init_data  (init_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .sat_flag   (sat_flag),
    .pass_count (pass_count)
  );

  task automatic set_deltas(input logic [15:0] v);
    for (int i = 0; i < 128; i++) dtab[i] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic write_init(input int a, input logic [15:0] v);
    @(negedge clk);
    init_we   = 1;
    init_addr = 7'(a);
    init_data = v;
    @(negedge clk);
    init_we = 0;
  endtask

  task automatic read_word(input int a, output logic [15:0] v);
    @(negedge clk);
    rd_addr = 7'(a);
    @(posedge clk);
    #1 v = rd_data;
  endtask

  // Pulses start, returns edge index (start edge = 0) where done is seen.
  task automatic run_pass(output int done_edge, output logic busy1);
    @(negedge clk);
    start = 1;
    @(posedge clk);
    #1 start = 0;
    done_edge = -1;
    busy1 = 0;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) busy1 = busy;
      if (done && done_edge < 0) done_edge = k;
      if (done_edge >= 0 && k > done_edge + 2) break;
    end
  endtask

  task automatic test_reset();
    logic [15:0] v;
    do_reset();
    #1;
    n_cmp++;
    if ({busy, done, sat_flag} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags got %b want 000", {busy, done, sat_flag});
    end
    n_cmp++;
    if (delta_addr !== 7'd0 || pass_count !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_cnt got da=%0d pc=%0d want 0 0", delta_addr, pass_count);
    end
    read_word(73, v);
    n_cmp++;
    if (v !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_mem73 got %h want 0000", v);
    end
  endtask

  task automatic test_basic();
    int de;
    logic b1;
    logic [15:0] v, exp;
    do_reset();
    set_deltas(16'sd512);
    write_init(0, 16'sd1024);
    run_pass(de, b1);
    n_cmp++;
    if (b1 !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_edge1 got %b want 1", b1);
    end
    n_cmp++;
    if (de != 148) begin
      n_bad++;
      $display("FAIL done_edge got %0d want 148", de);
    end
    n_cmp++;
    if (pass_count !== 16'd1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_pc got pc=%0d busy=%b want 1 0", pass_count, busy);
    end
    for (int i = 0; i < 74; i++) begin
      read_word(i, v);
      exp = (i == 0) ? 16'sd1536 : 16'sd512;
      n_cmp++;
      if (v !== exp) begin
        n_bad++;
        $display("FAIL basic_mem[%0d] got %h want %h", i, v, exp);
      end
    end
    n_cmp++;
    if (sat_flag !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_sat got %b want 0", sat_flag);
    end
  endtask

  task automatic test_saturation();
    int de;
    logic b1;
    logic [15:0] v;
    do_reset();
    set_deltas(16'h0000);
    dtab[5]  = 16'h0200;
    dtab[70] = 16'hFE00;
    write_init(5, 16'h7F00);
    write_init(70, 16'h8100);
    run_pass(de, b1);
    read_word(5, v);
    n_cmp++;
    if (v !== 16'h7FFF) begin
      n_bad++;
      $display("FAIL sat_pos got %h want 7fff", v);
    end
    read_word(70, v);
    n_cmp++;
    if (v !== 16'h8000) begin
      n_bad++;
      $display("FAIL sat_neg got %h want 8000", v);
    end
    read_word(6, v);
    n_cmp++;
    if (v !== 16'h0000) begin
      n_bad++;
      $display("FAIL sat_other got %h want 0000", v);
    end
    n_cmp++;
    if (sat_flag !== 1'b1) begin
      n_bad++;
      $display("FAIL sat_flag got %b want 1", sat_flag);
    end
    set_deltas(16'h0000);
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    n_cmp++;
    if (sat_flag !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL sat_clear got sat=%b busy=%b want 0 1", sat_flag, busy);
    end
    repeat (160) @(negedge clk);
    n_cmp++;
    if (sat_flag !== 1'b0 || pass_count !== 16'd2) begin
      n_bad++;
      $display("FAIL sat_pass2 got sat=%b pc=%0d want 0 2", sat_flag, pass_count);
    end
    read_word(5, v);
    n_cmp++;
    if (v !== 16'h7FFF) begin
      n_bad++;
      $display("FAIL sat_hold got %h want 7fff", v);
    end
  endtask

  task automatic test_busy_ignore();
    int de;
    logic [15:0] v;
    do_reset();
    set_deltas(16'sd1);
    @(negedge clk);
    start = 1;
    @(posedge clk);
    #1 start = 0;
    de = -1;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk);
      #1;
      if (k == 29) begin
        start     = 1;
        init_we   = 1;
        init_addr = 7'd3;
        init_data = 16'h1234;
      end else begin
        start   = 0;
        init_we = 0;
      end
      if (done && de < 0) de = k;
      if (de >= 0 && k > de + 5) break;
    end
    n_cmp++;
    if (de != 148) begin
      n_bad++;
      $display("FAIL busy_done_edge got %0d want 148", de);
    end
    n_cmp++;
    if (busy !== 1'b0 || pass_count !== 16'd1) begin
      n_bad++;
      $display("FAIL busy_restart got busy=%b pc=%0d want 0 1", busy, pass_count);
    end
    read_word(3, v);
    n_cmp++;
    if (v !== 16'h0001) begin
      n_bad++;
      $display("FAIL busy_mem3 got %h want 0001", v);
    end
  endtask

  task automatic test_init_edges();
    int de;
    logic b1;
    logic [15:0] v;
    do_reset();
    write_init(2, 16'h0055);
    @(negedge clk);
    rd_addr   = 7'd2;
    init_we   = 1;
    init_addr = 7'd2;
    init_data = 16'h00AA;
    @(posedge clk);
    #1 v = rd_data;
    init_we = 0;
    n_cmp++;
    if (v !== 16'h0055) begin
      n_bad++;
      $display("FAIL rd_old got %h want 0055", v);
    end
    write_init(80, 16'h7777);
    read_word(80, v);
    n_cmp++;
    if (v !== 16'h0000) begin
      n_bad++;
      $display("FAIL rd_oob got %h want 0000", v);
    end
    set_deltas(16'sd1);
    @(negedge clk);
    init_we   = 1;
    init_addr = 7'd10;
    init_data = 16'sd100;
    start     = 1;
    @(negedge clk);
    init_we = 0;
    start   = 0;
    repeat (160) @(negedge clk);
    read_word(10, v);
    n_cmp++;
    if (v !== 16'sd101) begin
      n_bad++;
      $display("FAIL init_start got %h want 0065", v);
    end
    read_word(2, v);
    n_cmp++;
    if (v !== 16'h00AB) begin
      n_bad++;
      $display("FAIL init_mem2 got %h want 00ab", v);
    end
    de = 0;
    b1 = 0;
  endtask

  task automatic test_mid_reset();
    int seen;
    logic [15:0] v;
    int bad;
    do_reset();
    set_deltas(16'sd1);
    write_init(1, 16'sd7);
    @(negedge clk);
    start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (59) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mrst_busy got %b want 0", busy);
    end
    rst = 0;
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1 if (done) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL mrst_done got %0d pulses want 0", seen);
    end
    n_cmp++;
    if (pass_count !== 16'd0) begin
      n_bad++;
      $display("FAIL mrst_pc got %0d want 0", pass_count);
    end
    bad = 0;
    for (int i = 0; i < 74; i++) begin
      read_word(i, v);
      if (v !== 16'h0000) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL mrst_mem got %0d nonzero words want 0", bad);
    end
  endtask

  task automatic test_clip();
    int de;
    logic b1;
    logic [15:0] v, exp;
    int bad;
`ifdef GRAD_CLIP_EN
    exp = 16'sd1024;
`else
    exp = 16'sd4096;
`endif
    do_reset();
    set_deltas(16'sd4096);
    run_pass(de, b1);
    bad = 0;
    for (int i = 0; i < 74; i++) begin
      read_word(i, v);
      if (v !== exp) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL clip_mem got %0d wrong words want 0 (val %h)", bad, exp);
    end
    n_cmp++;
    if (sat_flag !== 1'b0 || de != 148) begin
      n_bad++;
      $display("FAIL clip_sat got sat=%b edge=%0d want 0 148", sat_flag, de);
    end
  endtask

  initial begin
    rst       = 1;
    start     = 0;
    init_we   = 0;
    init_addr = 0;
    init_data = 0;
    rd_addr   = 0;
    set_deltas(16'h0000);
    test_reset();
    test_basic();
    test_saturation();
    test_busy_ignore();
    test_init_edges();
    test_mid_reset();
    test_clip();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
